chan_clk_sched: RTL and testbench
=================================

# chan_clk_sched

Audio channel clock scheduler for the POKEY core. It divides the 1.79 MHz machine-cycle enable into the 64 kHz and 15 kHz base clocks, and selects each channel's clock source from the AUDCTL control bits. It runs the four AUDF divide-down counters, including 16-bit channel joining and the fast-clock start-up offset. Its outputs are per-channel underflow ticks that drive the poly-counter/distortion stage.

## Interface
Parameters:
- DIV64, 28: machine cycles per 64 kHz base tick.
- DIV15, 114: machine cycles per 15 kHz base tick.

Ports:
- clk  in  1  system clock; all state updates on the falling edge.
- rstn  in  1  reset, asynchronous, active-low.
- enn  in  1  machine-cycle enable; state advances only on a falling clk edge with enn=1 (an "enn edge").
- sel15Khz, ch4Bits16, ch2Bits16, enFastClk3, enFastClk1  in  1 each  decoded AUDCTL bits.
- audf1, audf2, audf3, audf4  in  8 each  AUDF register values.
- stimer  in  1  STIMER write strobe, sampled on enn edges.
- base64k, base15k  out  1 each  base-clock ticks.
- chTick  out  4  channel underflow ticks; bit 0 is channel 1.

## Operation
- Two free-running prescalers count enn edges.
  - p64 runs 0..DIV64-1; base64k is set on the enn edge where p64 wraps to 0.
  - p15 runs 0..DIV15-1; base15k is set the same way.
- Base clock: base = sel15Khz ? base15k-event : base64k-event.
- Channel clock events:
  - ch1: enFastClk1 ? every enn edge : base.
  - ch3: enFastClk3 ? every enn edge : base.
  - ch2: base when ch2Bits16=0; when joined, the pair uses the ch1 source.
  - ch4: same as ch2, using ch4Bits16 and the ch3 source.
- Counters: c1..c4, 8 bits each.
  - Unjoined channel: on a clock event with cN=0, emit chTick[N] and reload cN=audfN; otherwise decrement. Period = audfN+1 events.
  - Joined pair (1/2 or 3/4): {c2,c1} (or {c4,c3}) acts as one 16-bit counter, reloaded with {audf2,audf1} (or {audf4,audf3}).
  - On pair underflow, chTick[1] (or chTick[3]) is emitted; chTick[0] (or chTick[2]) stays 0.
- Fast-clock offset:
  - Applies to channels 1 and 3 when the fast clock is selected.
  - Every reload also loads a 3-bit delay counter: dly = 3 in 8-bit mode, 6 in joined mode.
  - While dly≠0, each event decrements dly only; the main counter holds.
  - Resulting periods: 8-bit fast = AUDF+4 machine cycles; 16-bit fast = AUDF16+7 machine cycles.
  - dly is ignored (forced 0) when the fast clock is not selected.
- stimer on an enn edge:
  - Every counter reloads from its AUDF source (joined pairs as 16-bit).
  - Fast channels also load dly.
  - All chTick outputs clear.
  - Prescalers are unaffected.
- AUDF writes take effect only at the next reload; no immediate reload on write.
- AUDCTL changes take effect on the next enn edge. Counter contents are kept, with no reload. Exact periods are guaranteed only from the first reload after a change or after stimer.

## Timing
- Reset (rstn=0, asynchronous): p64, p15, c1..c4 and dly are cleared; base64k, base15k and chTick are all 0.
- After reset release, the first clock event of any channel finds its counter at 0: it ticks and reloads.
- Ticks are registered:
  - set on the enn edge of the underflow event;
  - cleared on the next enn edge unless a new underflow occurs.
  - With enn tied high, each tick is 1 clk wide.
- Latency: the underflow tick and the reload occur on the same enn edge. There is no additional pipeline stage.
- Simultaneous events:
  - stimer together with an underflow: stimer wins. No tick; reload only.
  - Base tick together with a fast-clock event: no conflict, because each channel has one source.
- No events while enn=0; every output holds.

## Test plan
- Reset: assert rstn=0 mid-count → all outputs 0 immediately, without waiting for a clock edge. After release with enn=1, base64k pulses 28 clk later and base15k 114 clk later, then periodically.
- 8-bit base clock: audf1=4, all AUDCTL bits 0, stimer → chTick[0] every 140 enn edges. Setting sel15Khz=1 then stimer → every 570 enn edges.
- Fast 8-bit: enFastClk1=1, audf1=0, stimer → chTick[0] every 4 enn edges. With audf1=255 → every 259.
- Fast joined pair: enFastClk1=1, ch2Bits16=1, audf2=0x01, audf1=0x00, stimer → chTick[1] every 263 enn edges; chTick[0] never asserts.
- Deferred AUDF write: writing audf3 mid-count keeps the current period until the next underflow, then the new period applies. A stimer coincident with a ch3 underflow → no chTick[2] on that edge, and the counter is reloaded.
- Hold behaviour: with enn held at 0 for 50 clk mid-count → no state change and no tick; counting resumes exactly where it stopped.

Source files
------------

// File: rtl/chan_clk_sched.sv
// POKEY audio channel clock scheduler: base-clock prescalers, per-channel clock
// selection and the four AUDF divide-down counters with 16-bit joining.
module chan_pair (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enn,
  input  logic       stimer_i,
  input  logic       base_i,
  input  logic       fast_i,
  input  logic       join_i,
  input  logic [7:0] audf_lo_i,
  input  logic [7:0] audf_hi_i,
  output logic [1:0] tick_o
);
  logic [7:0]  lo_q, lo_d, hi_q, hi_d;
  logic [2:0]  dly_q, dly_d, dly_eff, dly_rl;
  logic [1:0]  tick_q, tick_d;
  logic [15:0] cnt16;
  logic        ev_lo, ev_hi;

  assign ev_lo   = fast_i | base_i;
  assign ev_hi   = join_i ? ev_lo : base_i;
  // The start-up offset only exists while the fast clock drives the low channel.
  assign dly_eff = fast_i ? dly_q : 3'd0;
  assign dly_rl  = fast_i ? (join_i ? 3'd6 : 3'd3) : 3'd0;
  assign cnt16   = {hi_q, lo_q};

  always_comb begin
    lo_d   = lo_q;
    hi_d   = hi_q;
    dly_d  = dly_eff;
    tick_d = '0;
    if (stimer_i) begin
      lo_d  = audf_lo_i;
      hi_d  = audf_hi_i;
      dly_d = dly_rl;
    end else if (join_i) begin
      if (ev_lo) begin
        if (dly_eff != 3'd0) dly_d = dly_eff - 3'd1;
        else if (cnt16 == 16'd0) begin
          tick_d[1] = 1'b1;
          lo_d      = audf_lo_i;
          hi_d      = audf_hi_i;
          dly_d     = dly_rl;
        end else {hi_d, lo_d} = cnt16 - 16'd1;
      end
    end else begin
      if (ev_lo) begin
        if (dly_eff != 3'd0) dly_d = dly_eff - 3'd1;
        else if (lo_q == 8'd0) begin
          tick_d[0] = 1'b1;
          lo_d      = audf_lo_i;
          dly_d     = dly_rl;
        end else lo_d = lo_q - 8'd1;
      end
      if (ev_hi) begin
        if (hi_q == 8'd0) begin
          tick_d[1] = 1'b1;
          hi_d      = audf_hi_i;
        end else hi_d = hi_q - 8'd1;
      end
    end
  end

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      lo_q   <= '0;
      hi_q   <= '0;
      dly_q  <= '0;
      tick_q <= '0;
    end else if (enn) begin
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      dly_q  <= dly_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;
endmodule

module chan_clk_sched #(
  parameter int DIV64 = 28,
  parameter int DIV15 = 114
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enn,
  input  logic       sel15Khz,
  input  logic       ch4Bits16,
  input  logic       ch2Bits16,
  input  logic       enFastClk3,
  input  logic       enFastClk1,
  input  logic [7:0] audf1,
  input  logic [7:0] audf2,
  input  logic [7:0] audf3,
  input  logic [7:0] audf4,
  input  logic       stimer,
  output logic       base64k,
  output logic       base15k,
  output logic [3:0] chTick
);
  localparam int W64 = $clog2(DIV64);
  localparam int W15 = $clog2(DIV15);

  logic [W64-1:0] p64_q, p64_d;
  logic [W15-1:0] p15_q, p15_d;
  logic           b64_q, b15_q, wrap64, wrap15, base;

  assign wrap64 = (p64_q == W64'(DIV64 - 1));
  assign wrap15 = (p15_q == W15'(DIV15 - 1));
  assign p64_d  = wrap64 ? '0 : p64_q + 1'b1;
  assign p15_d  = wrap15 ? '0 : p15_q + 1'b1;

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      p64_q <= '0;
      p15_q <= '0;
      b64_q <= 1'b0;
      b15_q <= 1'b0;
    end else if (enn) begin
      p64_q <= p64_d;
      p15_q <= p15_d;
      b64_q <= wrap64;
      b15_q <= wrap15;
    end
  end

  // Counters are clocked by the registered base pulse, one enn edge after the wrap.
  assign base    = sel15Khz ? b15_q : b64_q;
  assign base64k = b64_q;
  assign base15k = b15_q;

  logic [1:0]      fast, join_;
  logic [1:0][7:0] audf_lo, audf_hi;
  logic [1:0][1:0] tick;

  assign fast    = {enFastClk3, enFastClk1};
  assign join_   = {ch4Bits16, ch2Bits16};
  assign audf_lo = {audf3, audf1};
  assign audf_hi = {audf4, audf2};

  for (genvar g = 0; g < 2; g++) begin : g_pair
    chan_pair u_pair (
      .clk       (clk),
      .rstn      (rstn),
      .enn       (enn),
      .stimer_i  (stimer),
      .base_i    (base),
      .fast_i    (fast[g]),
      .join_i    (join_[g]),
      .audf_lo_i (audf_lo[g]),
      .audf_hi_i (audf_hi[g]),
      .tick_o    (tick[g])
    );
  end

  assign chTick = tick;
endmodule

// File: tb/tb_chan_clk_sched.sv
// Bench for chan_clk_sched: directed period checks plus random traffic against
// an integer reference model stepped once per enn edge.
module tb_chan_clk_sched;
  logic clk = 1'b0, rstn = 1'b0, enn = 1'b0, stimer = 1'b0;
  logic sel15Khz = 1'b0, ch4Bits16 = 1'b0, ch2Bits16 = 1'b0;
  logic enFastClk3 = 1'b0, enFastClk1 = 1'b0;
  logic [7:0] audf1 = '0, audf2 = '0, audf3 = '0, audf4 = '0;
  logic base64k, base15k;
  logic [3:0] chTick;

  int vectors = 0, miscompares = 0;
  int en_cnt = 0;
  int last[4];
  int cnt[4];
  int iv[4][$];

  int m_p64, m_p15, m_c[4], m_dly[2];
  bit m_b64, m_b15;
  logic [3:0] m_tk;

  always #5 clk = ~clk;

  chan_clk_sched dut (
    .clk(clk), .rstn(rstn), .enn(enn), .sel15Khz(sel15Khz),
    .ch4Bits16(ch4Bits16), .ch2Bits16(ch2Bits16),
    .enFastClk3(enFastClk3), .enFastClk1(enFastClk1),
    .audf1(audf1), .audf2(audf2), .audf3(audf3), .audf4(audf4),
    .stimer(stimer), .base64k(base64k), .base15k(base15k), .chTick(chTick)
  );

  function automatic void model_reset();
    m_p64 = 0; m_p15 = 0; m_b64 = 0; m_b15 = 0; m_tk = '0;
    for (int i = 0; i < 4; i++) m_c[i] = 0;
    m_dly[0] = 0; m_dly[1] = 0;
  endfunction

  function automatic void model_step();
    bit base, fst, jn;
    int alo, ahi, lo, hi, v;
    logic [3:0] nt = '0;
    base  = sel15Khz ? m_b15 : m_b64;
    m_b64 = (m_p64 == 27); m_p64 = (m_p64 + 1) % 28;
    m_b15 = (m_p15 == 113); m_p15 = (m_p15 + 1) % 114;
    for (int p = 0; p < 2; p++) begin
      lo  = 2 * p; hi = lo + 1;
      fst = p ? enFastClk3 : enFastClk1;
      jn  = p ? ch4Bits16 : ch2Bits16;
      alo = p ? audf3 : audf1;
      ahi = p ? audf4 : audf2;
      if (!fst) m_dly[p] = 0;
      if (stimer) begin
        m_c[lo] = alo; m_c[hi] = ahi;
        m_dly[p] = fst ? (jn ? 6 : 3) : 0;
      end else if (jn) begin
        if (fst || base) begin
          if (m_dly[p] > 0) m_dly[p]--;
          else begin
            v = m_c[hi] * 256 + m_c[lo];
            if (v == 0) begin nt[hi] = 1; v = ahi * 256 + alo; m_dly[p] = fst ? 6 : 0; end
            else v--;
            m_c[hi] = v / 256; m_c[lo] = v % 256;
          end
        end
      end else begin
        if (fst || base) begin
          if (m_dly[p] > 0) m_dly[p]--;
          else if (m_c[lo] == 0) begin nt[lo] = 1; m_c[lo] = alo; m_dly[p] = fst ? 3 : 0; end
          else m_c[lo]--;
        end
        if (base) begin
          if (m_c[hi] == 0) begin nt[hi] = 1; m_c[hi] = ahi; end
          else m_c[hi]--;
        end
      end
    end
    m_tk = nt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_meas();
    for (int i = 0; i < 4; i++) begin last[i] = -1; cnt[i] = 0; iv[i].delete(); end
  endtask

  function automatic int get_iv(input int ch, input int n);
    if (iv[ch].size() > n) return iv[ch][n];
    return -1;
  endfunction

  // One clk: model advances on the same enn edge the DUT sees, outputs compared at posedge.
  task automatic cyc();
    bit stepped = enn;
    if (enn) begin model_step(); en_cnt++; end
    @(negedge clk);
    @(posedge clk);
    chk("base64k", base64k, m_b64);
    chk("base15k", base15k, m_b15);
    chk("chTick", chTick, m_tk);
    if (stepped)
      for (int i = 0; i < 4; i++)
        if (chTick[i]) begin
          cnt[i]++;
          if (last[i] >= 0) iv[i].push_back(en_cnt - last[i]);
          last[i] = en_cnt;
        end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_stimer();
    stimer = 1'b1; cyc(); stimer = 1'b0; clear_meas();
  endtask

  initial begin
    int f64, f15, found;
    logic [5:0] snap;
    model_reset(); clear_meas();
    #1;
    chk("rst_out", {base64k, base15k, chTick}, 6'd0);
    @(posedge clk);
    rstn = 1'b1; enn = 1'b1;

    f64 = -1; f15 = -1;
    for (int k = 1; k <= 120; k++) begin
      cyc();
      if (base64k && f64 < 0) f64 = k;
      if (base15k && f15 < 0) f15 = k;
    end
    chk("first64", f64, 28);
    chk("first15", f15, 114);

    audf1 = 8'd4; do_stimer(); run(400);
    chk("base8_per", get_iv(0, 0), 140);
    sel15Khz = 1'b1; do_stimer(); run(1250);
    chk("base15_per", get_iv(0, 0), 570);

    sel15Khz = 1'b0; enFastClk1 = 1'b1; audf1 = 8'd0; do_stimer(); run(20);
    chk("fast0_per", get_iv(0, 0), 4);
    audf1 = 8'd255; do_stimer(); run(600);
    chk("fast255_per", get_iv(0, 0), 259);

    ch2Bits16 = 1'b1; audf2 = 8'h01; audf1 = 8'h00; do_stimer(); run(600);
    chk("join_per", get_iv(1, 0), 263);
    chk("join_lo_quiet", cnt[0], 0);
    ch2Bits16 = 1'b0;

    enFastClk3 = 1'b1; audf3 = 8'd10; do_stimer();
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin cyc(); found = chTick[2]; end
    chk("wait_ch3", found, 1);
    iv[2].delete();
    run(5); audf3 = 8'd20; run(60);
    chk("defer_old", get_iv(2, 0), 14);
    chk("defer_new", get_iv(2, 1), 24);

    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin cyc(); found = chTick[2]; end
    chk("wait_ch3b", found, 1);
    run(23); stimer = 1'b1; cyc(); stimer = 1'b0;
    chk("stimer_wins", chTick[2], 1'b0);
    run(23);
    chk("post_stimer_q", chTick[2], 1'b0);
    cyc();
    chk("post_stimer_t", chTick[2], 1'b1);

    audf1 = 8'd0; do_stimer(); run(6);
    enn = 1'b0; snap = {base64k, base15k, chTick};
    for (int k = 0; k < 50; k++) begin cyc(); chk("hold", {base64k, base15k, chTick}, snap); end
    enn = 1'b1; run(12);
    chk("resume_iv1", get_iv(0, 1), 4);
    chk("resume_iv2", get_iv(0, 2), 4);

    for (int k = 0; k < 3000; k++) begin
      enn    = ($urandom % 8) != 0;
      stimer = ($urandom % 200) == 0;
      if (($urandom % 100) == 0) begin
        {sel15Khz, ch4Bits16, ch2Bits16, enFastClk3, enFastClk1} = 5'($urandom);
      end
      if (($urandom % 50) == 0) begin
        audf1 = 8'($urandom_range(0, 15)); audf2 = 8'($urandom_range(0, 3));
        audf3 = 8'($urandom);              audf4 = 8'($urandom_range(0, 2));
      end
      cyc();
    end
    stimer = 1'b0; enn = 1'b1;

    run(3);
    #2 rstn = 1'b0;
    #1 chk("async_rst", {base64k, base15k, chTick}, 6'd0);
    model_reset();
    @(posedge clk); rstn = 1'b1;
    run(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
